// File: rtl/fb_reader_pkg.sv
// Shared types and defaults for the frame-buffer read path.
// Package name fb_pkg; imported by fb_reader and fb_skid_fifo.
package fb_pkg;

  localparam int H_ACTIVE_DEF = 640;
  localparam int V_ACTIVE_DEF = 480;
  localparam int FRAME_PIXELS = H_ACTIVE_DEF * V_ACTIVE_DEF;
  localparam int ADDR_W_DEF   = 19;
  localparam int DATA_W_DEF   = 8;

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DRAIN
  } state_t;

  // One output beat: markers travel with the pixel through the FIFO.
  typedef struct packed {
    logic                  sof;
    logic                  eol;
    logic [DATA_W_DEF-1:0] data;
  } beat_t;

  // Largest even line index below n (last line visited by a 2x2 scan).
  function automatic int last_even(input int n);
    return ((n - 1) / 2) * 2;
  endfunction

endpackage

// File: rtl/fb_reader_if.sv
// Frame-reader bus: control, frame-buffer read port and pixel stream.
// master = reader side, slave = environment (buffer + downstream).
interface fb_reader_if #(
  parameter int ADDR_W = fb_pkg::ADDR_W_DEF,
  parameter int DATA_W = fb_pkg::DATA_W_DEF
);
  logic              start;
  logic              busy;
  logic              done;
  logic              rd_en;
  logic [ADDR_W-1:0] rd_addr;
  logic [DATA_W-1:0] rd_data;
  logic              m_valid;
  logic              m_ready;
  logic [DATA_W-1:0] m_data;
  logic              m_sof;
  logic              m_eol;

  modport master (
    input  start, rd_data, m_ready,
    output busy, done, rd_en, rd_addr, m_valid, m_data, m_sof, m_eol
  );

  modport slave (
    output start, rd_data, m_ready,
    input  busy, done, rd_en, rd_addr, m_valid, m_data, m_sof, m_eol
  );
endinterface

// File: rtl/fb_reader_skid_fifo.sv
// Two-entry output FIFO for fb_reader with fall-through on empty:
// a beat pushed while the FIFO is empty is visible at the head in the
// same cycle, so a continuously ready consumer never lets it fill.
module fb_skid_fifo
  import fb_pkg::*;
#(
  parameter type beat_t = fb_pkg::beat_t
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       push,
  input  beat_t      push_beat,
  input  logic       pop,
  output beat_t      head,
  output logic [1:0] count,
  output logic       empty
);

  beat_t mem [2];
  logic  wr_ptr;
  logic  rd_ptr;
  logic  store;
  logic  drop;

  // Head selection and storage/retire decisions.
  always_comb begin
    empty = (count == 2'd0) && !push;
    store = push && !((count == 2'd0) && pop);
    drop  = pop && (count != 2'd0);
    if (count != 2'd0)
      head = mem[rd_ptr];
    else if (push)
      head = push_beat;
    else
      head = '0;
  end

  // Occupancy and pointers.
  always_ff @(posedge clk) begin
    if (rst) begin
      count  <= '0;
      wr_ptr <= 1'b0;
      rd_ptr <= 1'b0;
    end else begin
      count <= count + {1'b0, push} - {1'b0, pop};
      if (store) wr_ptr <= ~wr_ptr;
      if (drop)  rd_ptr <= ~rd_ptr;
    end
  end

  // Storage array (contents are don't-care while count says empty).
  always_ff @(posedge clk) begin
    if (store) mem[wr_ptr] <= push_beat;
  end

endmodule

// File: rtl/fb_reader.sv
// Frame-buffer read master: raster-scans one frame per start pulse and
// re-emits the 1-cycle-latency read data as a valid/ready pixel stream.
// Optional 2x2 decimation when FB_READER_DECIMATE_EN is defined.
module fb_reader
  import fb_pkg::*;
#(
  parameter int H_ACTIVE = H_ACTIVE_DEF,
  parameter int V_ACTIVE = V_ACTIVE_DEF,
  parameter int ADDR_W   = ADDR_W_DEF,
  parameter int DATA_W   = DATA_W_DEF
) (
  input logic        clk,
  input logic        rst,
  fb_reader_if.master bus
);

`ifdef FB_READER_DECIMATE_EN
  localparam int X_STEP    = 2;
  localparam int Y_STEP    = 2;
  localparam int X_LAST    = H_ACTIVE - 2;
  localparam int Y_LAST    = last_even(V_ACTIVE);
  // From (H-2, y) to (0, y+2): rest of this line plus one skipped line.
  localparam int LINE_JUMP = H_ACTIVE + 2;
`else
  localparam int X_STEP    = 1;
  localparam int Y_STEP    = 1;
  localparam int X_LAST    = H_ACTIVE - 1;
  localparam int Y_LAST    = V_ACTIVE - 1;
  localparam int LINE_JUMP = 1;
`endif

  typedef struct packed {
    logic              sof;
    logic              eol;
    logic [DATA_W-1:0] data;
  } pix_t;

  state_t            state;
  state_t            state_n;
  logic [ADDR_W-1:0] addr;
  logic [ADDR_W-1:0] x;
  logic [ADDR_W-1:0] y;
  logic              rd_en;
  logic              inflight;
  logic              sof_q;
  logic              eol_q;
  logic              done_n;
  logic              done_q;
  logic              pix_sof;
  logic              pix_eol;
  logic              last_pix;
  logic [2:0]        credit;

  pix_t              push_beat;
  pix_t              head;
  logic [1:0]        fifo_count;
  logic              fifo_empty;
  logic              pop;

  // Markers for the pixel at the current scan position.
  always_comb begin
    pix_sof  = (x == '0) && (y == '0);
    pix_eol  = (x == ADDR_W'(X_LAST));
    last_pix = pix_eol && (y == ADDR_W'(Y_LAST));
  end

  // Next state, read issue (credit-gated) and done request.
  always_comb begin
    state_n = state;
    rd_en   = 1'b0;
    done_n  = 1'b0;
    // Only registered terms, so m_ready never reaches rd_en.
    credit  = {1'b0, fifo_count} + {2'b00, inflight};
    case (state)
      IDLE: begin
        if (bus.start) state_n = RUN;
      end
      RUN: begin
        rd_en = (credit < 3'd2);
        if (rd_en && last_pix) state_n = DRAIN;
      end
      DRAIN: begin
        if (!inflight && (fifo_count == 2'd0)) begin
          state_n = IDLE;
          done_n  = 1'b1;
        end
      end
      default: state_n = IDLE;
    endcase
  end

  // FSM state register.
  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_n;
  end

  // Scan counters: zeroed on an accepted start, advanced per issued read,
  // parked on the last pixel so rd_addr never runs past the frame.
  always_ff @(posedge clk) begin
    if (rst) begin
      addr <= '0;
      x    <= '0;
      y    <= '0;
    end else if ((state == IDLE) && bus.start) begin
      addr <= '0;
      x    <= '0;
      y    <= '0;
    end else if (rd_en && !last_pix) begin
      if (pix_eol) begin
        x    <= '0;
        y    <= y + ADDR_W'(Y_STEP);
        addr <= addr + ADDR_W'(LINE_JUMP);
      end else begin
        x    <= x + ADDR_W'(X_STEP);
        addr <= addr + ADDR_W'(X_STEP);
      end
    end
  end

  // Read pipeline: markers follow the address so they meet rd_data.
  always_ff @(posedge clk) begin
    if (rst) begin
      inflight <= 1'b0;
      sof_q    <= 1'b0;
      eol_q    <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      inflight <= rd_en;
      sof_q    <= pix_sof;
      eol_q    <= pix_eol;
      done_q   <= done_n;
    end
  end

  // Returned beat and downstream pop.
  always_comb begin
    push_beat.sof  = sof_q;
    push_beat.eol  = eol_q;
    push_beat.data = bus.rd_data;
    pop            = !fifo_empty && bus.m_ready;
  end

  fb_skid_fifo #(
    .beat_t(pix_t)
  ) u_fifo (
    .clk      (clk),
    .rst      (rst),
    .push     (inflight),
    .push_beat(push_beat),
    .pop      (pop),
    .head     (head),
    .count    (fifo_count),
    .empty    (fifo_empty)
  );

  assign bus.busy    = (state != IDLE);
  assign bus.done    = done_q;
  assign bus.rd_en   = rd_en;
  assign bus.rd_addr = addr;
  assign bus.m_valid = !fifo_empty;
  assign bus.m_data  = head.data;
  assign bus.m_sof   = head.sof;
  assign bus.m_eol   = head.eol;

endmodule

// File: tb/tb_fb_reader.sv
// Self-checking bench for fb_reader on a 4x3 frame; the buffer model
// returns addr[7:0] one cycle after rd_en. Honours FB_READER_DECIMATE_EN.
module tb_fb_reader;

  localparam int H = 4;
  localparam int V = 3;
`ifdef FB_READER_DECIMATE_EN
  localparam int NBEATS = (H / 2) * ((V + 1) / 2);
`else
  localparam int NBEATS = H * V;
`endif

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  fb_reader_if #(.ADDR_W(19), .DATA_W(8)) bus ();

  fb_reader #(
    .H_ACTIVE(H),
    .V_ACTIVE(V),
    .ADDR_W  (19),
    .DATA_W  (8)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus.master)
  );

  // Frame-buffer model: junk on cycles without a read.
  always @(posedge clk) bus.rd_data <= bus.rd_en ? bus.rd_addr[7:0] : 8'($urandom);

  typedef struct {
    logic [7:0] data;
    logic       sof;
    logic       eol;
  } exp_t;

  exp_t       expq[$];
  int         checks = 0;
  int         errors = 0;
  int         cyc = 0;
  int         occ, dones, beats, first_valid_cyc, last_pop_cyc, start_cyc;
  logic       prev_rd_en, prev_stall, prev_busy, check_zero;
  logic [9:0] prev_beat;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Expected frame straight from the scan rules.
  task automatic load_frame();
    exp_t e;
    expq.delete();
`ifdef FB_READER_DECIMATE_EN
    for (int yy = 0; yy < V; yy += 2)
      for (int xx = 0; xx < H; xx += 2) begin
        e.data = 8'(yy * H + xx); e.sof = (xx == 0 && yy == 0); e.eol = (xx == H - 2);
        expq.push_back(e);
      end
`else
    for (int a = 0; a < H * V; a++) begin
      e.data = 8'(a); e.sof = (a == 0); e.eol = ((a % H) == H - 1);
      expq.push_back(e);
    end
`endif
  endtask

  task automatic observe();
    logic pop;
    pop = bus.m_valid && bus.m_ready;
    if (check_zero) begin
      chk("rst_busy", bus.busy, 0);
      chk("rst_done", bus.done, 0);
      chk("rst_rd_en", bus.rd_en, 0);
      chk("rst_rd_addr", bus.rd_addr, 0);
      chk("rst_m_valid", bus.m_valid, 0);
      chk("rst_m_sof", bus.m_sof, 0);
      chk("rst_m_eol", bus.m_eol, 0);
      chk("rst_m_data", bus.m_data, 0);
      check_zero = 1'b0;
    end
    if (bus.rd_en) chk("credit", (occ + int'(prev_rd_en)) < 2, 1);
    if (prev_stall) begin
      chk("stall_valid", bus.m_valid, 1);
      chk("stall_hold", {bus.m_sof, bus.m_eol, bus.m_data}, prev_beat);
    end
    if (bus.m_valid) begin
      if (expq.size() == 0) chk("spurious_valid", bus.m_valid, 0);
      else chk("beat", {bus.m_data, bus.m_sof, bus.m_eol}, {expq[0].data, expq[0].sof, expq[0].eol});
      if (first_valid_cyc < 0) first_valid_cyc = cyc;
    end
    if (pop && expq.size() > 0) begin
      void'(expq.pop_front());
      beats++;
      last_pop_cyc = cyc;
    end
    if (bus.done) begin
      dones++;
      chk("done_after_last", expq.size(), 0);
      chk("busy_falls", bus.busy, 0);
      chk("busy_before_done", prev_busy, 1);
    end
    occ        = occ + int'(prev_rd_en) - int'(pop);
    prev_rd_en = bus.rd_en;
    prev_stall = bus.m_valid && !bus.m_ready;
    prev_beat  = {bus.m_sof, bus.m_eol, bus.m_data};
    prev_busy  = bus.busy;
  endtask

  // One clock: drive inputs just after the edge, sample at the falling edge.
  task automatic cycle(input logic rdy, input logic st, input logic r);
    @(posedge clk);
    #1;
    bus.m_ready = rdy;
    bus.start   = st;
    rst         = r;
    cyc++;
    @(negedge clk);
    if (r) begin
      expq.delete();
      occ        = 0;
      prev_rd_en = 1'b0;
      prev_stall = 1'b0;
      prev_busy  = 1'b0;
      check_zero = 1'b1;
    end else begin
      observe();
    end
  endtask

  // mode 0: ready high; 1: ready 1,0,0 pattern; 2: random ready;
  // 3: ready high plus a second start once 6 pixels are accepted.
  task automatic run_frame(input int mode);
    logic rdy, st, pulsed;
    int   k;
    load_frame();
    dones = 0; beats = 0; first_valid_cyc = -1; pulsed = 1'b0;
    cycle((mode == 1) ? 1'b1 : ((mode == 2) ? 1'($urandom) : 1'b1), 1'b1, 1'b0);
    start_cyc = cyc;
    k = 1;
    while (dones == 0 && k < 300) begin
      rdy = 1'b1; st = 1'b0;
      if (mode == 1) rdy = ((k % 3) == 0);
      if (mode == 2) rdy = 1'($urandom);
      if (mode == 3 && beats == 6 && !pulsed) begin st = 1'b1; pulsed = 1'b1; end
      cycle(rdy, st, 1'b0);
      k++;
    end
    for (int i = 0; i < 4; i++) cycle(1'b1, 1'b0, 1'b0);
    chk("frame_done_once", dones, 1);
    chk("beat_count", beats, NBEATS);
    chk("queue_empty", expq.size(), 0);
    if (mode == 0) begin
      chk("first_latency", first_valid_cyc - start_cyc, 2);
      chk("throughput", last_pop_cyc - first_valid_cyc, NBEATS - 1);
    end
  endtask

  initial begin
    rst = 1'b1; bus.start = 1'b0; bus.m_ready = 1'b0;
    occ = 0; prev_rd_en = 1'b0; prev_stall = 1'b0; prev_busy = 1'b0; check_zero = 1'b0;
    dones = 0; beats = 0; first_valid_cyc = -1;
    for (int i = 0; i < 3; i++) cycle(1'b0, 1'b0, 1'b1);
    cycle(1'b0, 1'b0, 1'b0);

    run_frame(0);
    run_frame(1);
    run_frame(2);
    run_frame(2);
    run_frame(3);

    // Reset mid-frame after 5 accepted pixels.
    load_frame();
    dones = 0; beats = 0; first_valid_cyc = -1;
    cycle(1'b1, 1'b1, 1'b0);
    for (int k = 0; k < 100 && beats < 5; k++) cycle(1'b1, 1'b0, 1'b0);
    chk("pre_reset_beats", beats, 5);
    cycle(1'b1, 1'b0, 1'b1);
    for (int i = 0; i < 5; i++) cycle(1'b1, 1'b0, 1'b0);
    chk("no_done_after_reset", dones, 0);
    run_frame(0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
